control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 155 +++++++++++++++
 tb/tb_control_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Moore FSM sequencing fetch/decode/execute for a 16-bit datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  OutState
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [2:0] C_ALU_ZERO = 3'b000;
    localparam logic [2:0] C_ALU_ADD  = 3'b001;
    localparam logic [2:0] C_ALU_SUB  = 3'b010;

    state_t      state_q, state_d;
    logic [11:0] operand_q;
    logic [11:0] operand_d;

    logic       pc_clr_q, pc_up_q, ir_ld_q, d_wr_q, rf_s_q, rf_w_en_q;
    logic [7:0] d_addr_q;
    logic [3:0] rf_w_addr_q, rf_ra_addr_q, rf_rb_addr_q, out_state_q;
    logic [2:0] alu_s0_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'b0001: state_d = S_STORE;
                    4'b0010: state_d = S_LOAD_A;
                    4'b0011: state_d = S_ADD;
                    4'b0100: state_d = S_SUB;
                    4'b0101: state_d = S_HALT;
                    default: state_d = S_NOOP;
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Operand fields are captured as the instruction leaves DECODE; the
    // same-edge value is used so execute-state outputs are valid on entry.
    assign operand_d = (state_q == S_DECODE) ? IR[11:0] : operand_q;

    // Outputs are registered from the next state, so each one lines up
    // exactly with the state it belongs to and Reset never reaches them
    // combinationally.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_INIT;
            operand_q    <= 12'd0;
            pc_clr_q     <= 1'b1;
            pc_up_q      <= 1'b0;
            ir_ld_q      <= 1'b0;
            d_addr_q     <= 8'd0;
            d_wr_q       <= 1'b0;
            rf_s_q       <= 1'b0;
            rf_w_addr_q  <= 4'd0;
            rf_w_en_q    <= 1'b0;
            rf_ra_addr_q <= 4'd0;
            rf_rb_addr_q <= 4'd0;
            alu_s0_q     <= C_ALU_ZERO;
            out_state_q  <= S_INIT;
        end else begin
            state_q      <= state_d;
            operand_q    <= operand_d;
            out_state_q  <= state_d;
            pc_clr_q     <= 1'b0;
            pc_up_q      <= 1'b0;
            ir_ld_q      <= 1'b0;
            d_addr_q     <= 8'd0;
            d_wr_q       <= 1'b0;
            rf_s_q       <= 1'b0;
            rf_w_addr_q  <= 4'd0;
            rf_w_en_q    <= 1'b0;
            rf_ra_addr_q <= 4'd0;
            rf_rb_addr_q <= 4'd0;
            alu_s0_q     <= C_ALU_ZERO;
            case (state_d)
                S_INIT: pc_clr_q <= 1'b1;
                S_FETCH: begin
                    pc_up_q <= 1'b1;
                    ir_ld_q <= 1'b1;
                end
                S_LOAD_A, S_LOAD_B: begin
                    d_addr_q    <= operand_d[11:4];
                    rf_w_addr_q <= operand_d[3:0];
                    rf_s_q      <= 1'b1;
                    rf_w_en_q   <= (state_d == S_LOAD_B);
                end
                S_STORE: begin
                    rf_ra_addr_q <= operand_d[11:8];
                    d_addr_q     <= operand_d[7:0];
                    d_wr_q       <= 1'b1;
                end
                S_ADD, S_SUB: begin
                    rf_ra_addr_q <= operand_d[11:8];
                    rf_rb_addr_q <= operand_d[7:4];
                    rf_w_addr_q  <= operand_d[3:0];
                    rf_w_en_q    <= 1'b1;
                    alu_s0_q     <= (state_d == S_ADD) ? C_ALU_ADD : C_ALU_SUB;
                end
                default: ;
            endcase
        end
    end

    assign PC_clr     = pc_clr_q;
    assign PC_up      = pc_up_q;
    assign IR_ld      = ir_ld_q;
    assign D_addr     = d_addr_q;
    assign D_wr       = d_wr_q;
    assign RF_s       = rf_s_q;
    assign RF_W_addr  = rf_w_addr_q;
    assign RF_W_en    = rf_w_en_q;
    assign RF_Ra_addr = rf_ra_addr_q;
    assign RF_Rb_addr = rf_rb_addr_q;
    assign ALU_s0     = alu_s0_q;
    assign OutState   = out_state_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Directed self-checking bench for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, rf_w_en;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, out_state;
    logic [2:0]  alu_s0;

    int tests_run = 0;
    int tests_failed = 0;

    control_unit dut (
        .Clk        (clk),
        .Reset      (rst),
        .IR         (ir),
        .PC_clr     (pc_clr),
        .PC_up      (pc_up),
        .IR_ld      (ir_ld),
        .D_addr     (d_addr),
        .D_wr       (d_wr),
        .RF_s       (rf_s),
        .RF_W_addr  (rf_w_addr),
        .RF_W_en    (rf_w_en),
        .RF_Ra_addr (rf_ra_addr),
        .RF_Rb_addr (rf_rb_addr),
        .ALU_s0     (alu_s0),
        .OutState   (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Order: PC_clr PC_up IR_ld D_addr D_wr RF_s W_addr W_en Ra Rb ALU State
    logic [32:0] outs;
    assign outs = {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr,
                   rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0, out_state};

    function automatic logic [32:0] ev(
        input logic pcclr, input logic pcup, input logic irld,
        input logic [7:0] da, input logic dwr, input logic rfs,
        input logic [3:0] wa, input logic wen, input logic [3:0] ra,
        input logic [3:0] rb, input logic [2:0] alu, input logic [3:0] st);
        return {pcclr, pcup, irld, da, dwr, rfs, wa, wen, ra, rb, alu, st};
    endfunction

    logic [32:0] E_INIT, E_FETCH, E_DECODE, E_NOOP, E_HALT;
    initial begin
        E_INIT   = ev(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd0);
        E_FETCH  = ev(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd1);
        E_DECODE = ev(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd2);
        E_NOOP   = ev(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd3);
        E_HALT   = ev(0, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 4'd9);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] exp_q[$];
        rst = 1'b1;
        ir  = 16'h0000;
        exp_q = '{E_INIT, E_INIT};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [32:0] exp_q[$];
        ir = 16'h3125;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'h00, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1, 4'd7)};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL add[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
    endtask

    task automatic test_load();
        logic [32:0] exp_q[$];
        ir = 16'h2A73;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'hA7, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 4'd4),
                  ev(0, 0, 0, 8'hA7, 0, 1, 4'h3, 1, 4'h0, 4'h0, 3'd0, 4'd5)};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL load[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
    endtask

    task automatic test_store();
        logic [32:0] exp_q[$];
        ir = 16'h14C2;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'hC2, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'd0, 4'd6)};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL store[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [32:0] exp_q[$];
        ir = 16'h4ABC;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'h00, 0, 0, 4'hC, 1, 4'hA, 4'hB, 3'd2, 4'd8)};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL sub[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
    endtask

    // Undefined opcodes and the real NOOP must both take the 3-cycle NOOP path.
    task automatic test_noop();
        logic [15:0] codes[3];
        codes = '{16'hF000, 16'h0000, 16'h6ABC};
        foreach (codes[c]) begin
            logic [32:0] exp_q[$];
            ir = codes[c];
            exp_q = '{E_FETCH, E_DECODE, E_NOOP};
            foreach (exp_q[i]) begin
                step();
                tests_run++;
                if (outs !== exp_q[i]) begin
                    tests_failed++;
                    $display("FAIL noop[%h][%0d]: got %h required %h",
                             codes[c], i, outs, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        ir = 16'h3125;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'h00, 0, 0, 4'h5, 1, 4'h1, 4'h2, 3'd1, 4'd7),
                  E_FETCH};
        foreach (exp_q[i]) begin
            step();
            if (i == 2) ir = 16'h14C2;
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
        step();
        tests_run++;
        if (outs !== E_DECODE) begin
            tests_failed++;
            $display("FAIL b2b_decode: got %h required %h", outs, E_DECODE);
        end
        step();
        tests_run++;
        if (outs !== ev(0, 0, 0, 8'hC2, 1, 0, 4'h0, 0, 4'h4, 4'h0, 3'd0, 4'd6)) begin
            tests_failed++;
            $display("FAIL b2b_store: got %h", outs);
        end
    endtask

    task automatic test_halt();
        ir = 16'h5000;
        step();
        tests_run++;
        if (outs !== E_FETCH) begin
            tests_failed++;
            $display("FAIL halt_fetch: got %h required %h", outs, E_FETCH);
        end
        step();
        tests_run++;
        if (outs !== E_DECODE) begin
            tests_failed++;
            $display("FAIL halt_decode: got %h required %h", outs, E_DECODE);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 3) ir = 16'h3125;
            tests_run++;
            if (outs !== E_HALT) begin
                tests_failed++;
                $display("FAIL halt_hold[%0d]: got %h required %h", k, outs, E_HALT);
            end
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (outs !== E_INIT) begin
            tests_failed++;
            $display("FAIL halt_reset: got %h required %h", outs, E_INIT);
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        logic [32:0] exp_q[$];
        ir = 16'h2A73;
        exp_q = '{E_FETCH, E_DECODE,
                  ev(0, 0, 0, 8'hA7, 0, 1, 4'h3, 0, 4'h0, 4'h0, 3'd0, 4'd4)};
        foreach (exp_q[i]) begin
            step();
            tests_run++;
            if (outs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL midload[%0d]: got %h required %h", i, outs, exp_q[i]);
            end
        end
        rst = 1'b1;
        step();
        tests_run++;
        if (outs !== E_INIT) begin
            tests_failed++;
            $display("FAIL midload_reset: got %h required %h", outs, E_INIT);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (outs !== E_FETCH) begin
            tests_failed++;
            $display("FAIL midload_refetch: got %h required %h", outs, E_FETCH);
        end
    endtask

    // Write enables to the register file and data memory must be exclusive.
    int overlap_cnt = 0;
    always @(negedge clk) begin
        if (rf_w_en === 1'b1 && d_wr === 1'b1) overlap_cnt++;
    end

    initial begin
        rst = 1'b1;
        ir  = 16'h0000;
        test_reset();
        test_add();
        test_load();
        test_store();
        test_sub();
        test_noop();
        test_back_to_back();
        test_halt();
        test_reset_mid_load();
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL wen_dwr_exclusive: got %0d overlaps required 0", overlap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
